// File: rtl/i2c_slave_target.sv
// ----------------------------------------------------------------------------
// i2c_slave_target
//   I2C target with a small auto-incrementing register file. It oversamples
//   scl/sda with the core clock, detects START/STOP, acknowledges SLAVE_ADDR,
//   stores written bytes and returns stored bytes on reads.
//
// Ports
//   i2c_core_clk_i  core clock (only clock of the block)
//   reset_ni        asynchronous active-low reset
//   scl_i, sda_i    resolved bus lines
//   sda_low_o       1 = pull sda low (open drain), 0 = release
//   busy_o          1 from START detect to STOP detect
//   wr_strobe_o     one-cycle pulse per data byte stored
//   wr_addr_o       register index of the stored byte (held between strobes)
//   wr_data_o       stored byte (held between strobes)
//   dbg_raddr_i     read-back index
//   dbg_rdata_o     mem[dbg_raddr_i], combinational
// ----------------------------------------------------------------------------
module i2c_slave_target #(
  parameter int         DATA_SIZE  = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_ADDR_W = 4
) (
  input  logic                  i2c_core_clk_i,
  input  logic                  reset_ni,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_low_o,
  output logic                  busy_o,
  output logic                  wr_strobe_o,
  output logic [MEM_ADDR_W-1:0] wr_addr_o,
  output logic [DATA_SIZE-1:0]  wr_data_o,
  input  logic [MEM_ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_SIZE-1:0]  dbg_rdata_o
);

  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam logic [MEM_ADDR_W-1:0] PTR_ONE = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // synchroniser stages (1,2) plus history stage (3)
  logic [2:0] scl_sync, sda_sync;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;

  state_t                  state, state_nxt;
  logic [2:0]              bit_cnt, bit_cnt_nxt;
  logic                    byte_full, byte_full_nxt;
  logic [DATA_SIZE-1:0]    shift, shift_nxt;
  logic                    rw, rw_nxt;
  logic                    first_byte, first_byte_nxt;
  logic                    nack, nack_nxt;
  logic [MEM_ADDR_W-1:0]   ptr, ptr_nxt;
  logic                    sda_low, sda_low_nxt;
  logic                    busy, busy_nxt;
  logic                    wr_strobe, wr_strobe_nxt;
  logic [MEM_ADDR_W-1:0]   wr_addr, wr_addr_nxt;
  logic [DATA_SIZE-1:0]    wr_data, wr_data_nxt;
  logic                    mem_we;
  logic [DATA_SIZE-1:0]    mem [DEPTH];
  logic [DATA_SIZE-1:0]    mem_rd;

  // Edges compare stage 2 against stage 3; START/STOP need scl steady high.
  assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
  assign start_det =  scl_sync[1] &  scl_sync[2] &  sda_sync[2] & ~sda_sync[1];
  assign stop_det  =  scl_sync[1] &  scl_sync[2] & ~sda_sync[2] &  sda_sync[1];
  assign sda_bit   =  sda_sync[1];
  assign mem_rd    =  mem[ptr];

  assign sda_low_o   = sda_low;
  assign busy_o      = busy;
  assign wr_strobe_o = wr_strobe;
  assign wr_addr_o   = wr_addr;
  assign wr_data_o   = wr_data;
  assign dbg_rdata_o = mem[dbg_raddr_i];

  // Input synchroniser and history stage, idle-high after reset.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  // Next-state and next-output logic of the protocol FSM.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    byte_full_nxt  = byte_full;
    shift_nxt      = shift;
    rw_nxt         = rw;
    first_byte_nxt = first_byte;
    nack_nxt       = nack;
    ptr_nxt        = ptr;
    sda_low_nxt    = sda_low;
    busy_nxt       = busy;
    wr_strobe_nxt  = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    mem_we         = 1'b0;

    if (start_det) begin
      state_nxt      = ADDR;
      bit_cnt_nxt    = 3'd7;
      byte_full_nxt  = 1'b0;
      busy_nxt       = 1'b1;
      sda_low_nxt    = 1'b0;
      first_byte_nxt = 1'b1;
    end else if (stop_det) begin
      state_nxt     = IDLE;
      busy_nxt      = 1'b0;
      sda_low_nxt   = 1'b0;
      byte_full_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, WR_BYTE: begin
          if (scl_rise && !byte_full) begin
            shift_nxt = {shift[DATA_SIZE-2:0], sda_bit};
            if (bit_cnt == 3'd0) begin
              byte_full_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt - 3'd1;
            end
          end else if (scl_fall && byte_full) begin
            byte_full_nxt = 1'b0;
            if (state == ADDR) begin
              if (shift[DATA_SIZE-1:1] == SLAVE_ADDR) begin
                sda_low_nxt = 1'b1;
                rw_nxt      = shift[0];
                state_nxt   = ADDR_ACK;
              end else begin
                sda_low_nxt = 1'b0;
                state_nxt   = IGNORE;
              end
            end else begin
              // every data byte is acknowledged; the first one sets the pointer
              sda_low_nxt = 1'b1;
              state_nxt   = WR_ACK;
              if (first_byte) begin
                ptr_nxt        = shift[MEM_ADDR_W-1:0];
                first_byte_nxt = 1'b0;
              end else begin
                mem_we        = 1'b1;
                wr_strobe_nxt = 1'b1;
                wr_addr_nxt   = ptr;
                wr_data_nxt   = shift;
                ptr_nxt       = ptr + PTR_ONE;
              end
            end
          end else begin
            state_nxt = state;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt   = 3'd7;
            byte_full_nxt = 1'b0;
            if (state == ADDR_ACK && rw) begin
              // release the ACK and present bit 7 of the first read byte together
              shift_nxt   = mem_rd;
              sda_low_nxt = ~mem_rd[DATA_SIZE-1];
              state_nxt   = RD_BYTE;
            end else begin
              sda_low_nxt = 1'b0;
              state_nxt   = WR_BYTE;
            end
          end else begin
            state_nxt = state;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low_nxt = 1'b0;
              ptr_nxt     = ptr + PTR_ONE;
              state_nxt   = RD_ACK;
            end else begin
              shift_nxt   = {shift[DATA_SIZE-2:0], 1'b0};
              sda_low_nxt = ~shift[DATA_SIZE-2];
              bit_cnt_nxt = bit_cnt - 3'd1;
            end
          end else begin
            state_nxt = state;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_nxt = sda_bit;
          end else if (scl_fall) begin
            if (!nack) begin
              shift_nxt   = mem_rd;
              sda_low_nxt = ~mem_rd[DATA_SIZE-1];
              bit_cnt_nxt = 3'd7;
              state_nxt   = RD_BYTE;
            end else begin
              sda_low_nxt = 1'b0;
              state_nxt   = IGNORE;
            end
          end else begin
            state_nxt = state;
          end
        end
        IDLE, IGNORE: begin
          sda_low_nxt = 1'b0;
        end
        default: begin
          state_nxt   = IDLE;
          sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

  // FSM and registered-output state.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      bit_cnt    <= 3'd7;
      byte_full  <= 1'b0;
      shift      <= {DATA_SIZE{1'b0}};
      rw         <= 1'b0;
      first_byte <= 1'b0;
      nack       <= 1'b0;
      ptr        <= {MEM_ADDR_W{1'b0}};
      sda_low    <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= {MEM_ADDR_W{1'b0}};
      wr_data    <= {DATA_SIZE{1'b0}};
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_full  <= byte_full_nxt;
      shift      <= shift_nxt;
      rw         <= rw_nxt;
      first_byte <= first_byte_nxt;
      nack       <= nack_nxt;
      ptr        <= ptr_nxt;
      sda_low    <= sda_low_nxt;
      busy       <= busy_nxt;
      wr_strobe  <= wr_strobe_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  // Register file, cleared by reset.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_SIZE{1'b0}};
      end
    end else if (mem_we) begin
      mem[ptr] <= shift;
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_target
//   Directed bench: a bit-banged I2C master drives scl/sda (sda resolved as a
//   wired-AND with the target's pull-down) and checks ACKs, read data, write
//   strobes, busy and the register file against hand-computed values.
// ----------------------------------------------------------------------------
module tb_i2c_slave_target;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_low_o, busy_o, wr_strobe_o;
  logic [3:0] wr_addr_o, dbg_raddr;
  logic [7:0] wr_data_o, dbg_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] strobe_q[$];
  int          low_cnt  = 0;
  int          wide_cnt = 0;
  logic        strobe_prev = 1'b0;

  assign sda_line = sda_m & ~sda_low_o;

  always #5 clk = ~clk;

  i2c_slave_target #(
    .DATA_SIZE (8),
    .SLAVE_ADDR(7'h50),
    .MEM_ADDR_W(4)
  ) dut (
    .i2c_core_clk_i(clk),
    .reset_ni      (reset_ni),
    .scl_i         (scl_m),
    .sda_i         (sda_line),
    .sda_low_o     (sda_low_o),
    .busy_o        (busy_o),
    .wr_strobe_o   (wr_strobe_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .dbg_raddr_i   (dbg_raddr),
    .dbg_rdata_o   (dbg_rdata)
  );

  // Monitor: record strobes, count pull-down cycles and over-long strobes.
  always @(negedge clk) begin
    if (wr_strobe_o) strobe_q.push_back({wr_addr_o, wr_data_o});
    if (sda_low_o) low_cnt++;
    if (wr_strobe_o && strobe_prev) wide_cnt++;
    strobe_prev = wr_strobe_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    cyc(2); sda_m = b; cyc(6); scl_m = 1'b1; cyc(8); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic r);
    cyc(2); sda_m = 1'b1; cyc(6); scl_m = 1'b1; cyc(4); r = sda_line; cyc(4); scl_m = 1'b0;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; scl_m = 1'b1; cyc(8); sda_m = 1'b0; cyc(8); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart;
    cyc(2); sda_m = 1'b1; cyc(6); scl_m = 1'b1; cyc(8); sda_m = 1'b0; cyc(8); scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    cyc(2); sda_m = 1'b0; cyc(6); scl_m = 1'b1; cyc(8); sda_m = 1'b1; cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(r);
      d[i] = r;
    end
    send_bit(~master_ack);
  endtask

  task automatic expect_strobe(input string tag, input logic [3:0] a, input logic [7:0] d);
    logic [11:0] g;
    if (strobe_q.size() != 0) g = strobe_q.pop_front();
    else g = 12'hfff;
    check(tag, {20'h0, g}, {20'h0, a, d});
  endtask

  task automatic peek_mem(input string tag, input logic [3:0] a, input logic [7:0] d);
    dbg_raddr = a; #1;
    check(tag, {24'h0, dbg_rdata}, {24'h0, d});
  endtask

  // Full write transaction: address, pointer byte, then n data bytes.
  task automatic write_regs(input string tag, input logic [7:0] p,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n);
    logic       ack;
    logic [7:0] dat [3];
    dat[0] = d0; dat[1] = d1; dat[2] = d2;
    i2c_start;
    check({tag, "_busy_s"}, {31'h0, busy_o}, 32'h1);
    send_byte(8'hA0, ack);
    check({tag, "_ack_addr"}, {31'h0, ack}, 32'h1);
    send_byte(p, ack);
    check({tag, "_ack_ptr"}, {31'h0, ack}, 32'h1);
    for (int i = 0; i < n; i++) begin
      send_byte(dat[i], ack);
      check({tag, "_ack_data"}, {31'h0, ack}, 32'h1);
    end
    i2c_stop;
    check({tag, "_busy_p"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         low0;

    reset_ni = 1'b0; scl_m = 1'b1; sda_m = 1'b1; dbg_raddr = 4'h0;
    cyc(3);
    check("rst_sda_low", {31'h0, sda_low_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_strobe", {31'h0, wr_strobe_o}, 32'h0);
    check("rst_wr_addr", {28'h0, wr_addr_o}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data_o}, 32'h0);
    peek_mem("rst_mem3", 4'h3, 8'h00);
    reset_ni = 1'b1;
    cyc(4);

    // T1: write A5,5A starting at register 3
    write_regs("t1", 8'h03, 8'hA5, 8'h5A, 8'h00, 2);
    expect_strobe("t1_strobe0", 4'h3, 8'hA5);
    expect_strobe("t1_strobe1", 4'h4, 8'h5A);
    check("t1_strobe_cnt", strobe_q.size(), 32'd0);
    peek_mem("t1_mem3", 4'h3, 8'hA5);
    peek_mem("t1_mem4", 4'h4, 8'h5A);
    check("t1_wr_hold", {20'h0, wr_addr_o, wr_data_o}, {20'h0, 4'h4, 8'h5A});

    // marker value in register 5 to observe the pointer after T2
    write_regs("pre", 8'h05, 8'hC3, 8'h00, 8'h00, 1);
    expect_strobe("pre_strobe", 4'h5, 8'hC3);

    // T2: set pointer 3, repeated START, read two bytes (ACK then NACK)
    i2c_start;
    send_byte(8'hA0, ack); check("t2_ack_addr_w", {31'h0, ack}, 32'h1);
    send_byte(8'h03, ack); check("t2_ack_ptr", {31'h0, ack}, 32'h1);
    i2c_rstart;
    check("t2_busy_sr", {31'h0, busy_o}, 32'h1);
    send_byte(8'hA1, ack); check("t2_ack_addr_r", {31'h0, ack}, 32'h1);
    recv_byte(1'b1, d);    check("t2_rd0", {24'h0, d}, 32'hA5);
    recv_byte(1'b0, d);    check("t2_rd1", {24'h0, d}, 32'h5A);
    recv_bit(r);           check("t2_ignore_rel", {31'h0, r}, 32'h1);
    i2c_stop;
    check("t2_no_strobe", strobe_q.size(), 32'd0);
    // pointer should now be 5: a fresh read returns the marker
    i2c_start;
    send_byte(8'hA1, ack); check("t2_ack_ptr_rd", {31'h0, ack}, 32'h1);
    recv_byte(1'b0, d);    check("t2_ptr_is_5", {24'h0, d}, 32'hC3);
    i2c_stop;

    // T3: address mismatch
    low0 = low_cnt;
    check("t3_busy_idle", {31'h0, busy_o}, 32'h0);
    i2c_start;
    check("t3_busy_s", {31'h0, busy_o}, 32'h1);
    send_byte(8'hA2, ack); check("t3_nack_addr", {31'h0, ack}, 32'h0);
    send_byte(8'h11, ack); check("t3_nack_data", {31'h0, ack}, 32'h0);
    i2c_stop;
    check("t3_busy_p", {31'h0, busy_o}, 32'h0);
    check("t3_never_low", low_cnt - low0, 32'd0);
    check("t3_no_strobe", strobe_q.size(), 32'd0);

    // T4: pointer wrap F -> 0 -> 1
    write_regs("t4", 8'h0F, 8'h11, 8'h22, 8'h33, 3);
    expect_strobe("t4_strobe0", 4'hF, 8'h11);
    expect_strobe("t4_strobe1", 4'h0, 8'h22);
    expect_strobe("t4_strobe2", 4'h1, 8'h33);
    peek_mem("t4_memF", 4'hF, 8'h11);
    peek_mem("t4_mem0", 4'h0, 8'h22);
    peek_mem("t4_mem1", 4'h1, 8'h33);

    // T5: reset while the target is driving the address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
    cyc(5);
    check("t5_acking", {31'h0, sda_low_o}, 32'h1);
    reset_ni = 1'b0; #1;
    check("t5_rst_sda", {31'h0, sda_low_o}, 32'h0);
    check("t5_rst_busy", {31'h0, busy_o}, 32'h0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(3);
    reset_ni = 1'b1;
    cyc(4);
    peek_mem("t5_mem3_clr", 4'h3, 8'h00);
    write_regs("t5b", 8'h03, 8'hA5, 8'h5A, 8'h00, 2);
    expect_strobe("t5b_strobe0", 4'h3, 8'hA5);
    expect_strobe("t5b_strobe1", 4'h4, 8'h5A);
    peek_mem("t5b_mem4", 4'h4, 8'h5A);

    // T6: STOP after four bits of a data byte
    i2c_start;
    send_byte(8'hA0, ack); check("t6_ack_addr", {31'h0, ack}, 32'h1);
    send_byte(8'h07, ack); check("t6_ack_ptr", {31'h0, ack}, 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop;
    check("t6_busy_p", {31'h0, busy_o}, 32'h0);
    check("t6_no_strobe", strobe_q.size(), 32'd0);
    peek_mem("t6_mem7", 4'h7, 8'h00);
    write_regs("t6b", 8'h08, 8'h77, 8'h00, 8'h00, 1);
    expect_strobe("t6b_strobe", 4'h8, 8'h77);
    peek_mem("t6b_mem8", 4'h8, 8'h77);

    check("strobe_one_cycle", wide_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
